// File: rtl/risc16ba.sv
// risc16ba: 16-bit, 8-register RISC core with an IF/RF/EX/WB pipeline.
// RF forwards from EX and WB; branches resolve in RF with a one-slot squash.

module risc16ba_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [2:0]  wa_i,
  input  logic [15:0] wd_i,
  input  logic [2:0]  ra1_i,
  input  logic [2:0]  ra2_i,
  output logic [15:0] rd1_o,
  output logic [15:0] rd2_o
);
  logic [15:0] register [0:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) register[i] <= '0;
    end else if (we_i) begin
      register[wa_i] <= wd_i;
    end
  end

  assign rd1_o = register[ra1_i];
  assign rd2_o = register[ra2_i];
endmodule

module risc16ba (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] iaddr,
  output logic        ioe,
  input  logic [15:0] idin,
  output logic [15:0] daddr,
  output logic        doe,
  input  logic [15:0] ddin,
  output logic [15:0] ddout,
  output logic        dwe0,
  output logic        dwe1
);
  typedef enum logic [3:0] {
    OP_NOP, OP_PASSB, OP_NOT, OP_XOR, OP_ADD, OP_SUB, OP_SL,
    OP_SR, OP_AND, OP_OR, OP_LD, OP_LBU, OP_ST, OP_SB
  } alu_op_e;

  function automatic alu_op_e decode(input logic [15:0] ir);
    alu_op_e op;
    op = OP_NOP;
    if (ir[15:11] == 5'b00000) begin
      case (ir[4:0])
        5'b00001: op = OP_PASSB;
        5'b00010: op = OP_NOT;
        5'b00011: op = OP_XOR;
        5'b00100: op = OP_ADD;
        5'b00101: op = OP_SUB;
        5'b01000: op = OP_SL;
        5'b01001: op = OP_SR;
        5'b01010: op = OP_AND;
        5'b01011: op = OP_OR;
        5'b10000: op = OP_ST;
        5'b10001: op = OP_LD;
        5'b10010: op = OP_SB;
        5'b10011: op = OP_LBU;
        default:  op = OP_NOP;
      endcase
    end else begin
      case (ir[15:11])
        5'b00001: op = OP_PASSB;
        5'b00100: op = OP_ADD;
        5'b00101: op = OP_AND;
        5'b00110: op = OP_OR;
        5'b00111: op = OP_PASSB;
        default:  op = OP_NOP;
      endcase
    end
    return op;
  endfunction

  function automatic logic writes_rd(input logic [15:0] ir);
    alu_op_e op;
    op = decode(ir);
    return !(op inside {OP_NOP, OP_ST, OP_SB});
  endfunction

  logic [15:0] if_pc, if_pc_d, if_ir, rf_pc;
  logic [15:0] rf_ir, rf_treg1, rf_treg2, rf_imm, rf_imm_d;
  logic [15:0] ex_ir, ex_result;
  logic [15:0] rd1, rd2, rd_fwd, rs_fwd, br_target;
  logic [15:0] alu_ain, alu_bin, alu_out;
  alu_op_e     alu_op;
  logic        reg_we, ex_we, br_taken, if_pc_we;

  assign if_pc_we = 1'b1;
  assign iaddr    = if_pc;
  assign ioe      = ~rst;

  risc16ba_reg_file reg_file_inst (
    .clk   (clk),
    .rst   (rst),
    .we_i  (reg_we),
    .wa_i  (ex_ir[10:8]),
    .wd_i  (ex_result),
    .ra1_i (if_ir[10:8]),
    .ra2_i (if_ir[7:5]),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign ex_we  = writes_rd(rf_ir);
  assign reg_we = writes_rd(ex_ir);

  // Youngest producer wins: EX (incl. load data) over WB over the array.
  always_comb begin
    rd_fwd = rd1;
    rs_fwd = rd2;
    if (reg_we && ex_ir[10:8] == if_ir[10:8]) rd_fwd = ex_result;
    if (reg_we && ex_ir[10:8] == if_ir[7:5])  rs_fwd = ex_result;
    if (ex_we && rf_ir[10:8] == if_ir[10:8])  rd_fwd = alu_out;
    if (ex_we && rf_ir[10:8] == if_ir[7:5])   rs_fwd = alu_out;
  end

  always_comb begin
    rf_imm_d = {{8{if_ir[7]}}, if_ir[7:0]};
    case (if_ir[15:11])
      5'b00001: rf_imm_d = {if_ir[7:0], 8'h00};
      5'b00101,
      5'b00110,
      5'b00111: rf_imm_d = {8'h00, if_ir[7:0]};
      5'b11100: rf_imm_d = {{5{if_ir[10]}}, if_ir[10:0]};
      default:  rf_imm_d = {{8{if_ir[7]}}, if_ir[7:0]};
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (if_ir[15:11])
      5'b11000: br_taken = (rd_fwd != 16'h0000);
      5'b11001: br_taken = (rd_fwd == 16'h0000);
      5'b11010: br_taken = rd_fwd[15];
      5'b11011: br_taken = ~rd_fwd[15];
      5'b11100: br_taken = 1'b1;
      default:  br_taken = 1'b0;
    endcase
  end

  assign br_target = rf_pc + 16'd2 + rf_imm_d;
  assign if_pc_d   = br_taken ? br_target : if_pc + 16'd2;

  assign alu_op  = decode(rf_ir);
  assign alu_ain = rf_treg1;
  assign alu_bin = (rf_ir[15:11] == 5'b00000) ? rf_treg2 : rf_imm;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_PASSB: alu_out = alu_bin;
      OP_NOT:   alu_out = ~alu_bin;
      OP_XOR:   alu_out = alu_ain ^ alu_bin;
      OP_ADD:   alu_out = alu_ain + alu_bin;
      OP_SUB:   alu_out = alu_ain - alu_bin;
      OP_SL:    alu_out = {alu_bin[14:0], 1'b0};
      OP_SR:    alu_out = {1'b0, alu_bin[15:1]};
      OP_AND:   alu_out = alu_ain & alu_bin;
      OP_OR:    alu_out = alu_ain | alu_bin;
      OP_LD:    alu_out = ddin;
      OP_LBU:   alu_out = {8'h00, rf_treg2[0] ? ddin[7:0] : ddin[15:8]};
      default:  alu_out = '0;
    endcase
  end

  assign daddr = rf_treg2;
  assign doe   = ~rst & (alu_op == OP_LD || alu_op == OP_LBU);
  assign dwe0  = ~rst & (alu_op == OP_ST || (alu_op == OP_SB && !daddr[0]));
  assign dwe1  = ~rst & (alu_op == OP_ST || (alu_op == OP_SB && daddr[0]));
  assign ddout = (alu_op == OP_SB) ? {rf_treg1[7:0], rf_treg1[7:0]}
                                   : rf_treg1;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc     <= '0;
      if_ir     <= '0;
      rf_pc     <= '0;
      rf_ir     <= '0;
      rf_treg1  <= '0;
      rf_treg2  <= '0;
      rf_imm    <= '0;
      ex_ir     <= '0;
      ex_result <= '0;
    end else begin
      if (if_pc_we) if_pc <= if_pc_d;
      if_ir     <= br_taken ? 16'h0000 : idin;
      rf_pc     <= if_pc;
      rf_ir     <= if_ir;
      rf_treg1  <= rd_fwd;
      rf_treg2  <= rs_fwd;
      rf_imm    <= rf_imm_d;
      ex_ir     <= rf_ir;
      ex_result <= alu_out;
    end
  end
endmodule

// File: tb/tb_risc16ba.sv
// tb_risc16ba: directed programs plus random programs compared
// against a sequential instruction-set model of the core.

module tb_risc16ba;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] iaddr, idin, daddr, ddin, ddout;
  logic        ioe, doe, dwe0, dwe1;

  logic [7:0]  imem [0:65535];
  logic [7:0]  dmem [0:65535];
  logic [7:0]  mm   [0:65535];
  logic [15:0] mr   [0:7];
  logic [15:0] prog [$];

  int checks = 0;
  int failures = 0;

  localparam int LUI = 1, ADDI = 4, ANDI = 5, ORI = 6, LLI = 7;
  localparam int BNEZ = 24, BEQZ = 25, BMI = 26, BPL = 27;
  localparam int F_ADD = 4, F_ST = 16, F_LD = 17, F_SB = 18, F_LBU = 19;

  always #5 clk = ~clk;

  risc16ba dut (
    .clk   (clk),
    .rst   (rst),
    .iaddr (iaddr),
    .ioe   (ioe),
    .idin  (idin),
    .daddr (daddr),
    .doe   (doe),
    .ddin  (ddin),
    .ddout (ddout),
    .dwe0  (dwe0),
    .dwe1  (dwe1)
  );

  assign idin = {imem[{iaddr[15:1], 1'b0}], imem[{iaddr[15:1], 1'b1}]};
  assign ddin = {dmem[{daddr[15:1], 1'b0}], dmem[{daddr[15:1], 1'b1}]};

  always @(posedge clk) begin
    if (dwe0) dmem[{daddr[15:1], 1'b0}] <= ddout[15:8];
    if (dwe1) dmem[{daddr[15:1], 1'b1}] <= ddout[7:0];
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rg(input logic [2:0] i);
    return dut.reg_file_inst.register[i];
  endfunction

  function automatic logic [15:0] R(input int rd, input int rs, input int f);
    return {5'b00000, rd[2:0], rs[2:0], f[4:0]};
  endfunction

  function automatic logic [15:0] I(input int op, input int rd, input int imm);
    return {op[4:0], rd[2:0], imm[7:0]};
  endfunction

  function automatic logic [15:0] JMPW(input int off);
    return {5'b11100, off[10:0]};
  endfunction

  task automatic load_prog;
    for (int i = 0; i < 65536; i++) imem[i] = 8'h00;
    foreach (prog[i]) begin
      imem[16'(2 * i)]     = prog[i][15:8];
      imem[16'(2 * i + 1)] = prog[i][7:0];
    end
  endtask

  // Architectural model: one instruction at a time, no pipeline.
  task automatic iss(input logic [15:0] halt);
    logic [15:0] pc, ir, a, b, nxt, s8, z8;
    logic [4:0]  op, f;
    logic [2:0]  rd, rs;
    pc = 16'h0000;
    for (int n = 0; n < 4000 && pc != halt; n++) begin
      ir  = {imem[pc], imem[pc + 16'd1]};
      op  = ir[15:11];
      f   = ir[4:0];
      rd  = ir[10:8];
      rs  = ir[7:5];
      a   = mr[rd];
      b   = mr[rs];
      s8  = {{8{ir[7]}}, ir[7:0]};
      z8  = {8'h00, ir[7:0]};
      nxt = pc + 16'd2;
      if (op == 5'd0) begin
        case (f)
          5'd1:  mr[rd] = b;
          5'd2:  mr[rd] = ~b;
          5'd3:  mr[rd] = a ^ b;
          5'd4:  mr[rd] = a + b;
          5'd5:  mr[rd] = a - b;
          5'd8:  mr[rd] = b << 1;
          5'd9:  mr[rd] = b >> 1;
          5'd10: mr[rd] = a & b;
          5'd11: mr[rd] = a | b;
          5'd16: begin
            mm[{b[15:1], 1'b0}] = a[15:8];
            mm[{b[15:1], 1'b1}] = a[7:0];
          end
          5'd17: mr[rd] = {mm[{b[15:1], 1'b0}], mm[{b[15:1], 1'b1}]};
          5'd18: mm[b] = a[7:0];
          5'd19: mr[rd] = {8'h00, mm[b]};
          default: ;
        endcase
      end else begin
        case (op)
          5'd1:  mr[rd] = {ir[7:0], 8'h00};
          5'd4:  mr[rd] = a + s8;
          5'd5:  mr[rd] = a & z8;
          5'd6:  mr[rd] = a | z8;
          5'd7:  mr[rd] = z8;
          5'd24: if (a != 16'h0000) nxt = nxt + s8;
          5'd25: if (a == 16'h0000) nxt = nxt + s8;
          5'd26: if (a[15])  nxt = nxt + s8;
          5'd27: if (!a[15]) nxt = nxt + s8;
          5'd28: nxt = nxt + {{5{ir[10]}}, ir[10:0]};
          default: ;
        endcase
      end
      pc = nxt;
    end
  endtask

  task automatic gen_random(input int k);
    int iops[5] = '{1, 4, 5, 6, 7};
    int halt, pc, lim, op;
    prog.delete();
    for (int r = 0; r < 8; r++) prog.push_back(I(LUI, r, $urandom_range(0, 255)));
    halt = 2 * (8 + k);
    for (int i = 8; i < 8 + k; i++) begin
      pc  = 2 * i;
      lim = (halt - pc - 2) / 2;
      if (lim > 63) lim = 63;
      case ($urandom_range(0, 9))
        0, 1, 2, 3:
          prog.push_back(R($urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 31)));
        4, 5, 6:
          prog.push_back(I(iops[$urandom_range(0, 4)], $urandom_range(0, 7),
                           $urandom_range(0, 255)));
        7:
          prog.push_back(I(24 + $urandom_range(0, 3), $urandom_range(0, 7),
                           2 * $urandom_range(0, lim)));
        8: begin
          do op = $urandom_range(1, 31);
          while (op inside {1, 4, 5, 6, 7, [24:28]});
          prog.push_back({op[4:0], 11'($urandom)});
        end
        default:
          prog.push_back(JMPW(2 * $urandom_range(0, lim)));
      endcase
    end
    prog.push_back(JMPW(-2));
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 65536; i++) begin
      imem[i] = 8'h00;
      dmem[i] = 8'($urandom);
    end

    // Reset, then a stream of NOPs
    rst = 1'b1;
    tick(1);
    chk("rst_ioe", 16'(ioe), 16'd0);
    chk("rst_strobes", 16'({doe, dwe0, dwe1}), 16'd0);
    tick(1);
    rst = 1'b0;
    chk("rst_iaddr", iaddr, 16'h0000);
    chk("rst_r7", rg(3'd7), 16'h0000);
    chk("rst_ex_ir", dut.ex_ir, 16'h0000);
    chk("rst_treg1", dut.rf_treg1, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("nop_iaddr", iaddr, 16'(2 * i));
      chk("nop_ioe", 16'(ioe), 16'd1);
      chk("nop_strobes", 16'({doe, dwe0, dwe1}), 16'd0);
    end

    // Back-to-back dependency chain, r3 must land with no bubbles
    prog = '{I(LLI, 1, 'h05), I(ADDI, 1, 'hFF), R(2, 1, F_ADD),
             I(LUI, 3, 'h12), JMPW(-2)};
    load_prog();
    do_reset();
    tick(7);
    chk("chain_r1", rg(3'd1), 16'h0004);
    chk("chain_r2", rg(3'd2), 16'h0004);
    chk("chain_r3", rg(3'd3), 16'h1200);

    // Word store then load-use
    prog = '{I(LUI, 1, 'hC0), I(LUI, 2, 'h12), I(ORI, 2, 'h34),
             R(2, 1, F_ST), R(3, 1, F_LD), R(3, 3, F_ADD), JMPW(-2)};
    load_prog();
    do_reset();
    tick(5);
    chk("st_daddr", daddr, 16'hC000);
    chk("st_ddout", ddout, 16'h1234);
    chk("st_we", 16'({dwe0, dwe1}), 16'd3);
    tick(10);
    chk("ld_r3", rg(3'd3), 16'h2468);
    chk("st_mem", {dmem[16'hC000], dmem[16'hC001]}, 16'h1234);

    // Byte store then byte load
    dmem[16'hC000] = 8'h5A;
    dmem[16'hC001] = 8'h00;
    prog = '{I(LUI, 1, 'hC0), I(ORI, 1, 'h01), I(LLI, 2, 'hAB),
             R(2, 1, F_SB), R(4, 1, F_LBU), JMPW(-2)};
    load_prog();
    do_reset();
    tick(5);
    chk("sb_daddr", daddr, 16'hC001);
    chk("sb_we", 16'({dwe0, dwe1}), 16'd1);
    chk("sb_ddout", 16'(ddout[7:0]), 16'h00AB);
    tick(10);
    chk("lbu_r4", rg(3'd4), 16'h00AB);
    chk("sb_mem", {dmem[16'hC000], dmem[16'hC001]}, 16'h5AAB);

    // Countdown loop, BEQZ and BMI
    prog = '{I(LLI, 1, 3), I(ADDI, 1, 'hFF), I(BNEZ, 1, 'hFC),
             I(ADDI, 5, 1), I(BEQZ, 1, 2), I(LLI, 6, 'h77),
             I(LUI, 7, 'h80), I(BMI, 7, 2), I(LLI, 6, 'h55), JMPW(-2)};
    load_prog();
    do_reset();
    tick(30);
    chk("br_r1", rg(3'd1), 16'h0000);
    chk("br_r5", rg(3'd5), 16'h0001);
    chk("br_r6", rg(3'd6), 16'h0000);
    chk("br_r7", rg(3'd7), 16'h8000);

    // PC wrap through a backward JMP from address 0
    prog = '{JMPW(-4)};
    load_prog();
    imem[16'hFFFE] = 8'h3B;
    imem[16'hFFFF] = 8'h42;
    do_reset();
    tick(2);
    chk("wrap_top", iaddr, 16'hFFFE);
    tick(1);
    chk("wrap_zero", iaddr, 16'h0000);
    tick(4);
    chk("wrap_r3", rg(3'd3), 16'h0042);

    // Reset during a store cycle, then JMP -2 spin
    dmem[16'hC000] = 8'hEE;
    dmem[16'hC001] = 8'hEE;
    prog = '{I(LUI, 1, 'hC0), I(LLI, 2, 'h99), R(2, 1, F_ST), JMPW(-2)};
    load_prog();
    do_reset();
    tick(4);
    rst = 1'b1;
    #1;
    chk("mrst_we", 16'({dwe0, dwe1}), 16'd0);
    tick(1);
    rst = 1'b0;
    chk("mrst_iaddr", iaddr, 16'h0000);
    chk("mrst_r1", rg(3'd1), 16'h0000);
    chk("mrst_mem", {dmem[16'hC000], dmem[16'hC001]}, 16'hEEEE);
    tick(5);
    chk("jmp_pc_a", iaddr, 16'h0006);
    tick(2);
    chk("jmp_pc_b", iaddr, 16'h0006);
    chk("jmp_mem", {dmem[16'hC000], dmem[16'hC001]}, 16'h0099);

    // Random programs against the instruction-set model
    for (int p = 0; p < 20; p++) begin
      gen_random(24);
      load_prog();
      for (int i = 0; i < 65536; i++) mm[i] = dmem[i];
      for (int r = 0; r < 8; r++) mr[r] = 16'h0000;
      iss(16'(2 * 32));
      do_reset();
      tick(2 * 32 + 12);
      for (int r = 0; r < 8; r++)
        chk($sformatf("rnd%0d_r%0d", p, r), rg(3'(r)), mr[r]);
      diffs = 0;
      for (int i = 0; i < 65536; i++) if (dmem[i] !== mm[i]) diffs++;
      chk($sformatf("rnd%0d_memdiff", p), 16'(diffs), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/risc16ba.md
# risc16ba

16-bit, 8-register RISC processor core with a 4-stage pipeline: IF, RF, EX, WB. It uses a Harvard-style bus with a separate instruction-fetch port and a byte-addressed data port, both wired to combinational (same-cycle) memories. Memory is big-endian (even byte = bits [15:8]); memory-mapped I/O such as LEDs at 0x200 is ordinary store traffic. Internal pipeline state stays named and hierarchically visible for bench probing.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- iaddr  out  16  instruction address; equals if_pc.
- ioe  out  1  instruction read enable; 1 whenever rst=0.
- idin  in  16  instruction word {mem[a&~1], mem[a|1]}, valid in the same cycle.
- daddr  out  16  data byte address.
- doe  out  1  data read enable.
- ddin  in  16  data read word, valid in the same cycle.
- ddout  out  16  data write word.
- dwe0  out  1  write ddout[15:8] to the even byte (daddr&~1).
- dwe1  out  1  write ddout[7:0] to the odd byte (daddr|1).

## Operation
- **Formats**
  - R: op[15:11]=00000, rd[10:8], rs[7:5], func[4:0].
  - I: op, rd, imm8[7:0].
- **R funcs** (result written to rd):
  - 00000 NOP; 00001 MV rs; 00010 NOT ~rs; 00011 XOR; 00100 ADD rd+rs; 00101 SUB rd−rs.
  - 01000 SL rs<<1; 01001 SR rs>>1 (logical); 01010 AND; 01011 OR.
  - 10000 ST word mem[rs]←rd; 10001 LD rd←word mem[rs].
  - 10010 SBU mem8[rs]←rd[7:0]; 10011 LBU rd←zext(mem8[rs]).
  - Any other func is a NOP.
- **I ops:**
  - 00001 LUI rd←{imm8,8'h00}; 00100 ADDI rd+sext(imm8); 00101 ANDI rd&zext; 00110 ORI rd|zext; 00111 LLI rd←zext(imm8).
  - 11000 BNEZ (rd≠0); 11001 BEQZ (rd=0); 11010 BMI (rd[15]=1); 11011 BPL (rd[15]=0). Target = pc+2+sext(imm8).
  - 11100 JMP: target = pc+2+sext(ir[10:0]).
  - Any other opcode is a NOP. Arithmetic is modulo 2^16, with no flags.
- **Pipeline registers:**
  - IF→RF: if_ir, rf_pc.
  - RF→EX: rf_ir, rf_treg1 (rd value), rf_treg2 (rs value), rf_imm (extended immediate).
  - EX→WB: ex_ir, ex_result.
  - ALU inputs alu_ain/alu_bin, selector alu_op; reg_we; if_pc_we (always 1, no stalls); register file instance reg_file_inst with array register[0:7].
- **IF:** iaddr=if_pc. Each edge: if_ir←idin, rf_pc←if_pc, if_pc←if_pc+2 (or the branch target).
- **RF:** decodes if_ir and reads rd/rs with forwarding. Priority:
  1. EX result of rf_ir, if it writes that register; includes load data from ddin.
  2. ex_result, if ex_ir writes that register.
  3. Register file.
  - Branches/JMP are resolved here on the forwarded rd value. If taken: if_pc←target and if_ir←0 (NOP), a 1-cycle penalty.
- **EX:** ALU or memory access.
  - daddr=rf_treg2.
  - LD/LBU: doe=1.
  - ST: ddout=rf_treg1, dwe0=dwe1=1. daddr[0] is ignored for word accesses.
  - SBU: ddout={rd[7:0],rd[7:0]}, dwe0=~daddr[0], dwe1=daddr[0].
  - LBU: byte = daddr[0] ? ddin[7:0] : ddin[15:8].
  - Otherwise doe=dwe0=dwe1=0, and daddr/ddout are don't-care.
- **WB:** register[rd(ex_ir)]←ex_result when reg_we. No hazard causes a stall.

## Timing
- Instruction fetched in cycle n: RF in n+1, EX (memory strobes) in n+2, register array updated at the end of n+3.
- Store data is committed by memory at the end of n+2.
- Taken branch fetched in cycle n: the instruction at pc+2 is squashed and the target is fetched in n+2.
- **Reset** (rst=1 at an edge):
  - if_pc=0; if_ir=rf_ir=ex_ir=0.
  - rf_treg1/2, rf_imm, ex_result=0; register[0..7]=0.
  - While rst=1: doe=dwe0=dwe1=0 and ioe=0.
  - The first fetch of address 0 happens in the first cycle with rst=0.
  - Mid-run reset discards all in-flight instructions, with no memory write in that cycle.
- PC wraps 0xFFFE→0x0000.

## Test plan
- **Reset then NOPs:** after rst, iaddr=0x0000, 0x0002, 0x0004… each cycle, with ioe=1 and doe=dwe0=dwe1=0.
- **Back-to-back dependency chain:** LLI r1,0x05; ADDI r1,0xFF; ADD r2,r1; LUI r3,0x12 → r1=0x0004, r2=0x0004, r3=0x1200, with no bubbles.
- **Word store/load:** r1=0xC000, r2=0x1234; ST r2,(r1) → daddr=C000, ddout=1234, dwe0=dwe1=1. Then an immediate LD r3,(r1) followed by ADD r3,r3 → r3=0x2468.
- **Byte store/load:** r1=0xC001, r2=0x00AB; SBU → dwe0=0, dwe1=1, ddout[7:0]=AB. Then LBU r4,(r1) → r4=0x00AB, with the even byte unchanged.
- **Branches:** r1=3, countdown loop of ADDI r1,0xFF; BNEZ r1,back → 3 iterations, then fall through with r1=0. The squashed instruction after each taken branch has no effect. BEQZ on 0 is taken; BMI on 0x8000 is taken.
- **JMP and reset mid-run:** JMP −2 loops forever at the same pc. Asserting rst during a ST cycle → no dwe pulse, and the pc returns to 0.
